ram_bridge: RTL and testbench

RAM_BRIDGE -- requirements
Module: ram_bridge

---
 rtl/ram_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_ram_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bridge.sv
// ram_bridge: single-outstanding load/store bridge from a core request port to a
// word-wide synchronous RAM with a fixed read latency (RD_LAT cycles).
// Optional feature macro: RAM_BRIDGE_MISALIGN_SPLIT_EN -- when defined, accesses that
// cross a word boundary are split into two beats; otherwise they are rejected.
module ram_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              req_unsigned,
    input  logic [1:0]        req_type,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, RESP} state_t;
`endif

    // Wait-state counter terminal value: capture happens in the last wait cycle.
    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    state_t            r_state, w_state_d;
    logic [1:0]        r_cnt, w_cnt_d;
    logic              r_we, r_uns, r_err;
    logic [1:0]        r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_data0;
    logic              w_accept, w_cap0, w_req_cross, w_req_err;
    logic [2:0]        w_req_size;
    logic [3:0]        w_size_mask;
    logic [31:0]       w_wdata_m, w_rd, w_ext;
    logic [ADDR_W-1:0] w_base;
    logic [4:0]        w_shamt;
`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
    logic              r_cross, w_cap1;
    logic [31:0]       r_data1;
    logic [7:0]        w_be;
    logic [63:0]       w_wd;
`else
    logic [3:0]        w_be;
    logic [31:0]       w_wd;
`endif

    assign w_accept    = req_valid && (r_state == IDLE);
    assign w_req_cross = ({1'b0, req_addr[1:0]} + w_req_size) > 3'd4;
`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
    assign w_req_err   = (req_type == 2'b11);
`else
    assign w_req_err   = (req_type == 2'b11) || w_req_cross;
`endif

    assign w_base    = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_shamt   = {r_addr[1:0], 3'b000};
    assign w_wdata_m = r_wdata & {{8{w_size_mask[3]}}, {8{w_size_mask[2]}},
                                  {8{w_size_mask[1]}}, {8{w_size_mask[0]}}};
    // Lane placement: the upper half of the wide vectors feeds beat 1.
`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
    assign w_be = {4'b0000, w_size_mask} << r_addr[1:0];
    assign w_wd = {32'h0, w_wdata_m} << w_shamt;
    assign w_rd = 32'({r_data1, r_data0} >> w_shamt);
`else
    assign w_be = w_size_mask << r_addr[1:0];
    assign w_wd = w_wdata_m << w_shamt;
    assign w_rd = r_data0 >> w_shamt;
`endif

    // Access size in bytes for the incoming request and byte mask for the held one.
    always_comb begin
        w_req_size  = 3'd4;
        w_size_mask = 4'b1111;
        case (req_type)
            2'b00:   w_req_size = 3'd1;
            2'b01:   w_req_size = 3'd2;
            default: w_req_size = 3'd4;
        endcase
        case (r_type)
            2'b00:   w_size_mask = 4'b0001;
            2'b01:   w_size_mask = 4'b0011;
            default: w_size_mask = 4'b1111;
        endcase
    end

    // Sign/zero extension of the merged load data.
    always_comb begin
        w_ext = w_rd;
        case (r_type)
            2'b00:   w_ext = r_uns ? {24'h0, w_rd[7:0]} : {{24{w_rd[7]}}, w_rd[7:0]};
            2'b01:   w_ext = r_uns ? {16'h0, w_rd[15:0]} : {{16{w_rd[15]}}, w_rd[15:0]};
            default: w_ext = w_rd;
        endcase
    end

    // Next-state, wait counter and read-capture strobes.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = 2'd0;
        w_cap0    = 1'b0;
`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
        w_cap1    = 1'b0;
`endif
        unique case (r_state)
            IDLE: if (req_valid) w_state_d = w_req_err ? RESP : ISSUE0;
            ISSUE0: begin
`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
                if (r_we) w_state_d = r_cross ? ISSUE1 : RESP;
`else
                if (r_we) w_state_d = RESP;
`endif
                else      w_state_d = WAIT0;
            end
            WAIT0: begin
                if (r_cnt == LAST_CNT) begin
                    w_cap0 = 1'b1;
`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
                    w_state_d = r_cross ? ISSUE1 : RESP;
`else
                    w_state_d = RESP;
`endif
                end else begin
                    w_cnt_d = r_cnt + 2'd1;
                end
            end
`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
            ISSUE1: w_state_d = r_we ? RESP : WAIT1;
            WAIT1: begin
                if (r_cnt == LAST_CNT) begin
                    w_cap1    = 1'b1;
                    w_state_d = RESP;
                end else begin
                    w_cnt_d = r_cnt + 2'd1;
                end
            end
`endif
            RESP:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Request fields latched on acceptance; read beats captured on their strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_type  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_data0 <= 32'h0;
`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
            r_cross <= 1'b0;
            r_data1 <= 32'h0;
`endif
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_err   <= w_req_err;
                r_type  <= req_type;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
                r_cross <= w_req_cross;
`endif
            end
            if (w_cap0) r_data0 <= mem_rdata;
`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
            if (w_cap1) r_data1 <= mem_rdata;
`endif
        end
    end

    // Outputs decoded from state; everything idles at zero outside its active state.
    always_comb begin
        req_ready = (r_state == IDLE);
        rsp_valid = (r_state == RESP);
        rsp_err   = (r_state == RESP) && r_err;
        rsp_rdata = ((r_state == RESP) && !r_we && !r_err) ? w_ext : 32'h0;
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (r_state == ISSUE0) begin
            mem_en   = 1'b1;
            mem_addr = w_base;
            if (r_we) begin
                mem_we    = w_be[3:0];
                mem_wdata = w_wd[31:0];
            end
        end
`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
        if (r_state == ISSUE1) begin
            mem_en   = 1'b1;
            mem_addr = w_base + ADDR_W'(4);
            if (r_we) begin
                mem_we    = w_be[7:4];
                mem_wdata = w_wd[63:32];
            end
        end
`endif
    end

endmodule

// File: tb/tb_ram_bridge.sv
// tb_ram_bridge: directed test of ram_bridge with two instances (RD_LAT=1 and RD_LAT=2)
// sharing one behavioural RAM; sel_l1 picks which instance is driven and observed.
module tb_ram_bridge;

    logic        clk;
    logic        rstn;
    logic        req_valid, req_we, req_unsigned, sel_l1;
    logic [1:0]  req_type;
    logic [31:0] req_addr, req_wdata;

    logic        l1_ready, l1_rv, l1_err, l1_en;
    logic [31:0] l1_rdata, l1_addr, l1_wdata, l1_mrdata;
    logic [3:0]  l1_we;
    logic        l2_ready, l2_rv, l2_err, l2_en;
    logic [31:0] l2_rdata, l2_addr, l2_wdata, l2_mrdata;
    logic [3:0]  l2_we;

    logic        s_ready, s_rv, s_err, m_en;
    logic [31:0] s_rdata, m_addr, m_wdata;
    logic [3:0]  m_we;

    logic [31:0] mem [256];
    logic [31:0] p1, p2;
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    int          cyc = 0;
    int          n_beats = 0;
    int          n_rsp = 0;
    int          b_cyc [64];
    logic [31:0] b_addr [64];
    logic [31:0] b_wdata [64];
    logic [3:0]  b_we [64];
    int          r_cyc;
    logic [31:0] r_rdata;
    logic        r_err;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          t_t0, t_b0, t_r0, t_lat, t_nb;
    logic [31:0] t_rdata;
    logic        t_err;

    ram_bridge #(.ADDR_W(32), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid & sel_l1), .req_ready(l1_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_unsigned(req_unsigned), .req_type(req_type), .rsp_valid(l1_rv),
        .rsp_rdata(l1_rdata), .rsp_err(l1_err), .mem_en(l1_en), .mem_we(l1_we),
        .mem_addr(l1_addr), .mem_wdata(l1_wdata), .mem_rdata(l1_mrdata)
    );

    ram_bridge #(.ADDR_W(32), .RD_LAT(2)) u_dut_l2 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid & ~sel_l1), .req_ready(l2_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_unsigned(req_unsigned), .req_type(req_type), .rsp_valid(l2_rv),
        .rsp_rdata(l2_rdata), .rsp_err(l2_err), .mem_en(l2_en), .mem_we(l2_we),
        .mem_addr(l2_addr), .mem_wdata(l2_wdata), .mem_rdata(l2_mrdata)
    );

    assign s_ready = sel_l1 ? l1_ready : l2_ready;
    assign s_rv    = sel_l1 ? l1_rv    : l2_rv;
    assign s_err   = sel_l1 ? l1_err   : l2_err;
    assign s_rdata = sel_l1 ? l1_rdata : l2_rdata;
    assign m_en    = sel_l1 ? l1_en    : l2_en;
    assign m_we    = sel_l1 ? l1_we    : l2_we;
    assign m_addr  = sel_l1 ? l1_addr  : l2_addr;
    assign m_wdata = sel_l1 ? l1_wdata : l2_wdata;
    assign l1_mrdata = p1;
    assign l2_mrdata = p2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge_we(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Behavioural RAM: p1 is read data one cycle after the beat, p2 two cycles after.
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_data;
        else if (m_en && m_we != 4'b0000)
            mem[m_addr[9:2]] <= merge_we(mem[m_addr[9:2]], m_wdata, m_we);
        p1 <= (m_en && m_we == 4'b0000) ? mem[m_addr[9:2]] : 32'hDEAD_DEAD;
        p2 <= p1;
    end

    // Beat and response log of the selected instance.
    always @(negedge clk) begin
        if (m_en && n_beats < 64) begin
            b_cyc[n_beats]   <= cyc;
            b_addr[n_beats]  <= m_addr;
            b_we[n_beats]    <= m_we;
            b_wdata[n_beats] <= m_wdata;
            n_beats          <= n_beats + 1;
        end
        if (s_rv) begin
            n_rsp   <= n_rsp + 1;
            r_cyc   <= cyc;
            r_rdata <= s_rdata;
            r_err   <= s_err;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        pre_en   = 1'b1;
        pre_idx  = addr[9:2];
        pre_data = data;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic launch(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] typ, input logic uns);
        t_b0 = n_beats;
        t_r0 = n_rsp;
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_type     = typ;
        req_unsigned = uns;
        @(negedge clk);
        t_t0 = cyc;
        check_eq("req_ready in idle", {31'h0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (n_rsp != t_r0) got = 1'b1;
        end
        check_eq({tag, " responded"}, {31'h0, got}, 32'd1);
        t_lat   = r_cyc - t_t0;
        t_rdata = r_rdata;
        t_err   = r_err;
        t_nb    = n_beats - t_b0;
        @(negedge clk);
        #1;
        check_eq({tag, " pulse ends"}, {31'h0, s_rv}, 32'd0);
        check_eq({tag, " rdata idle"}, s_rdata, 32'h0);
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] typ, input logic uns,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_nb);
        launch(we, addr, wdata, typ, uns);
        wait_rsp(tag);
        check_eq({tag, " latency"}, t_lat, exp_lat);
        check_eq({tag, " rdata"}, t_rdata, exp_rdata);
        check_eq({tag, " err"}, {31'h0, t_err}, {31'h0, exp_err});
        check_eq({tag, " beats"}, t_nb, exp_nb);
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [31:0] exp_addr,
                              input logic [3:0] exp_we, input logic chk_wd,
                              input logic [31:0] exp_wd, input int exp_rel);
        int k;
        k = t_b0 + idx;
        if (k < 64) begin
            check_eq({tag, " beat addr"}, b_addr[k], exp_addr);
            check_eq({tag, " beat we"}, {28'h0, b_we[k]}, {28'h0, exp_we});
            check_eq({tag, " beat cycle"}, b_cyc[k] - t_t0, exp_rel);
            if (chk_wd) check_eq({tag, " beat wdata"}, b_wdata[k], exp_wd);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " req_ready"}, {31'h0, s_ready}, 32'd1);
        check_eq({tag, " rsp_valid"}, {31'h0, s_rv}, 32'd0);
        check_eq({tag, " rsp_err"}, {31'h0, s_err}, 32'd0);
        check_eq({tag, " rsp_rdata"}, s_rdata, 32'h0);
        check_eq({tag, " mem_en"}, {31'h0, m_en}, 32'd0);
        check_eq({tag, " mem_we"}, {28'h0, m_we}, 32'd0);
        check_eq({tag, " mem_addr"}, m_addr, 32'h0);
        check_eq({tag, " mem_wdata"}, m_wdata, 32'h0);
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_unsigned = 1'b0;
        req_type = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
        sel_l1 = 1'b0; pre_en = 1'b0; pre_idx = 8'h0; pre_data = 32'h0;

        preload(32'h0000_0100, 32'h8000_1234);
        preload(32'h0000_0200, 32'h0000_0000);
        preload(32'hFFFF_FFFC, 32'hBEEF_0000);
        preload(32'h0000_0000, 32'h0000_CAFE);
        preload(32'h0000_0004, 32'h0000_00F1);
        preload(32'h0000_0010, 32'h0000_0000);
        preload(32'h0000_0014, 32'h0000_0000);

        @(negedge clk);
        #1;
        check_idle_outputs("reset l2");
        sel_l1 = 1'b1;
        #1;
        check_idle_outputs("reset l1");
        @(negedge clk);
        rstn = 1'b1;

        // RD_LAT = 2 instance
        sel_l1 = 1'b0;
        txn("st_b 0x203", 1'b1, 32'h203, 32'h1234_56AB, 2'b00, 1'b0, 2, 32'h0, 1'b0, 1);
        check_beat("st_b 0x203", 0, 32'h200, 4'b1000, 1'b1, 32'hAB00_0000, 1);
        txn("ld_h 0x102", 1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 4, 32'hFFFF_8000, 1'b0, 1);
        check_beat("ld_h 0x102", 0, 32'h100, 4'b0000, 1'b0, 32'h0, 1);

        // RD_LAT = 1 instance
        sel_l1 = 1'b1;
        txn("ld_bu 0x101", 1'b0, 32'h101, 32'h0, 2'b00, 1'b1, 3, 32'h0000_0012, 1'b0, 1);
        check_beat("ld_bu 0x101", 0, 32'h100, 4'b0000, 1'b0, 32'h0, 1);
        txn("ld_b 0x203", 1'b0, 32'h203, 32'h0, 2'b00, 1'b0, 3, 32'hFFFF_FFAB, 1'b0, 1);
        txn("st_h 0x102", 1'b1, 32'h102, 32'h1234_BEEF, 2'b01, 1'b0, 2, 32'h0, 1'b0, 1);
        check_beat("st_h 0x102", 0, 32'h100, 4'b1100, 1'b1, 32'hBEEF_0000, 1);
        txn("ld_w 0x100", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 3, 32'hBEEF_1234, 1'b0, 1);
        txn("ld_hu 0x102", 1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 3, 32'h0000_BEEF, 1'b0, 1);
        txn("reserved", 1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 1, 32'h0, 1'b1, 0);

`ifdef RAM_BRIDGE_MISALIGN_SPLIT_EN
        sel_l1 = 1'b0;
        txn("st_w 0x11", 1'b1, 32'h11, 32'h1122_3344, 2'b10, 1'b0, 3, 32'h0, 1'b0, 2);
        check_beat("st_w 0x11 b0", 0, 32'h10, 4'b1110, 1'b1, 32'h2233_4400, 1);
        check_beat("st_w 0x11 b1", 1, 32'h14, 4'b0001, 1'b1, 32'h0000_0011, 2);
        sel_l1 = 1'b1;
        txn("ld_w wrap", 1'b0, 32'hFFFF_FFFE, 32'h0, 2'b10, 1'b1, 5, 32'hCAFE_BEEF, 1'b0, 2);
        check_beat("ld_w wrap b0", 0, 32'hFFFF_FFFC, 4'b0000, 1'b0, 32'h0, 1);
        check_beat("ld_w wrap b1", 1, 32'h0, 4'b0000, 1'b0, 32'h0, 3);
        txn("ld_w 0x11", 1'b0, 32'h11, 32'h0, 2'b10, 1'b0, 5, 32'h1122_3344, 1'b0, 2);
        sel_l1 = 1'b0;
        txn("ld_h 0x3", 1'b0, 32'h3, 32'h0, 2'b01, 1'b0, 7, 32'hFFFF_F100, 1'b0, 2);
        check_beat("ld_h 0x3 b1", 1, 32'h4, 4'b0000, 1'b0, 32'h0, 4);
`else
        sel_l1 = 1'b1;
        txn("ld_h 0x3 reject", 1'b0, 32'h3, 32'h0, 2'b01, 1'b0, 1, 32'h0, 1'b1, 0);
        sel_l1 = 1'b0;
        txn("st_w 0x11 reject", 1'b1, 32'h11, 32'h1122_3344, 2'b10, 1'b0, 1, 32'h0, 1'b1, 0);
`endif

        // Reset asserted while the RD_LAT=2 instance is in WAIT0 (cycle T+2).
        sel_l1 = 1'b0;
        launch(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_idle_outputs("mid reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_eq("mid reset no rsp", n_rsp - t_r0, 32'd0);
        check_eq("mid reset beats", n_beats - t_b0, 32'd1);
        txn("ld_w after reset", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 4, 32'hBEEF_1234, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
